// File: rtl/gate_vector_checker.sv
// Exhaustive two-input gate checker: steps {a,b} through 00,01,10,11, samples c
// after a settle window and compares against the TRUTH table.
module gate_vector_checker #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 1,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             c,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_vec,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] scnt;
  logic       sample;
  logic       mismatch;
  logic [3:0] vec_next;

  // Case inequality so that an X or Z from the gate is reported as a failure.
  always_comb begin
    sample   = (state == DRIVE) && (scnt >= SETTLE_C);
    mismatch = sample && (c !== TRUTH[idx]);
    vec_next = err_vec;
    if (mismatch) vec_next[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      scnt    <= 4'd0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_vec <= 4'd0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= DRIVE;
            idx     <= 2'd0;
            scnt    <= 4'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b1;
            pass    <= 1'b0;
            err_vec <= 4'd0;
          end
        end
        DRIVE: begin
          if (!sample) begin
            scnt <= scnt + 4'd1;
          end else begin
            err_vec <= vec_next;
            if (idx != 2'd3) begin
              idx    <= idx + 2'd1;
              scnt   <= 4'd0;
              {a, b} <= idx + 2'd1;
            end else begin
              state <= DONE;
              idx   <= 2'd0;
              scnt  <= 4'd0;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (vec_next == 4'd0);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Clear has priority over a same-edge mismatch.
      if (clr)
        err_cnt <= '0;
      else if (mismatch && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: three parameterisations, behavioural gate
// models on c, and a scoreboard of expected end-of-run results.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, start_v, clr_v;
  logic [2:0] mode0, mode1, mode2;
  logic       c0, c1, c2;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] vec0, vec1, vec2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic       xv;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string      tag;
    logic [3:0] vec;
    logic       pass;
    logic [7:0] cnt;
    int         dcyc;
  } exp_t;
  exp_t sb[$];

  // Gate models: 0 NAND, 1 stuck-1, 2 X, 3 stuck-0, 4 NOR.
  function automatic logic model(input logic [2:0] m, input logic x, input logic y, input logic xval);
    case (m)
      3'd0:    return ~(x & y);
      3'd1:    return 1'b1;
      3'd2:    return xval;
      3'd3:    return 1'b0;
      default: return ~(x | y);
    endcase
  endfunction

  assign c0 = model(mode0, a0, b0, xv);
  assign c1 = model(mode1, a1, b1, xv);
  assign c2 = model(mode2, a2, b2, xv);

  gate_vector_checker u0 (
    .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .clr(clr_v[0]), .c(c0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0), .err_vec(vec0), .err_cnt(cnt0)
  );

  gate_vector_checker #(.CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .clr(clr_v[1]), .c(c1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1), .err_vec(vec1), .err_cnt(cnt1)
  );

  gate_vector_checker #(.TRUTH(4'b0001), .SETTLE(0)) u2 (
    .clk(clk), .rst_n(rst_v[2]), .start(start_v[2]), .clr(clr_v[2]), .c(c2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2), .err_vec(vec2), .err_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic getObs(input int sel, output logic oa, output logic ob, output logic obusy,
                        output logic odone, output logic opass, output logic [3:0] ovec,
                        output logic [7:0] ocnt);
    case (sel)
      0: begin oa = a0; ob = b0; obusy = busy0; odone = done0; opass = pass0; ovec = vec0; ocnt = cnt0; end
      1: begin oa = a1; ob = b1; obusy = busy1; odone = done1; opass = pass1; ovec = vec1; ocnt = {6'd0, cnt1}; end
      default: begin oa = a2; ob = b2; obusy = busy2; odone = done2; opass = pass2; ovec = vec2; ocnt = cnt2; end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Pulses start for one cycle; afterwards cyc counts cycles from the accepting edge.
  task automatic startRun(input int sel, input logic with_clr);
    @(negedge clk);
    start_v[sel] = 1'b1;
    clr_v[sel]   = with_clr;
    @(negedge clk);
    start_v[sel] = 1'b0;
    clr_v[sel]   = 1'b0;
    cyc = 1;
  endtask

  task automatic applyStimulus(input int sel, input logic with_clr, input string tag,
                               input logic [3:0] vec, input logic ps, input logic [7:0] cnt,
                               input int dcyc);
    exp_t e;
    e.tag = tag; e.vec = vec; e.pass = ps; e.cnt = cnt; e.dcyc = dcyc;
    sb.push_back(e);
    startRun(sel, with_clr);
  endtask

  task automatic checkOutput(input int sel);
    exp_t e;
    logic oa, ob, obusy, odone, opass;
    logic [3:0] ovec;
    logic [7:0] ocnt;
    int s1, last;
    e    = sb.pop_front();
    s1   = (sel == 2) ? 1 : 2;
    last = 4 * s1;
    getObs(sel, oa, ob, obusy, odone, opass, ovec, ocnt);
    while (odone !== 1'b1 && cyc < 40) begin
      if (cyc >= 1 && cyc <= last) begin
        chk({e.tag, "_busy"}, 32'(obusy), 32'd1);
        chk({e.tag, "_ab"}, 32'({oa, ob}), 32'((cyc - 1) / s1));
      end
      step();
      getObs(sel, oa, ob, obusy, odone, opass, ovec, ocnt);
    end
    chk({e.tag, "_done_seen"}, 32'(odone), 32'd1);
    chk({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.dcyc));
    chk({e.tag, "_busy_end"}, 32'(obusy), 32'd0);
    chk({e.tag, "_ab_end"}, 32'({oa, ob}), 32'd0);
    chk({e.tag, "_pass"}, 32'(opass), 32'(e.pass));
    chk({e.tag, "_err_vec"}, 32'(ovec), 32'(e.vec));
    chk({e.tag, "_err_cnt"}, 32'(ocnt), 32'(e.cnt));
    step();
    getObs(sel, oa, ob, obusy, odone, opass, ovec, ocnt);
    chk({e.tag, "_done_pulse"}, 32'(odone), 32'd0);
    chk({e.tag, "_pass_hold"}, 32'(opass), 32'(e.pass));
    chk({e.tag, "_vec_hold"}, 32'(ovec), 32'(e.vec));
  endtask

  initial begin
    logic oa, ob, obusy, odone, opass;
    logic [3:0] ovec, xvec;
    logic [7:0] ocnt, xcnt;
    logic [3:0] nand_tt;
    int done_count;

    xv = 1'bx;
    nand_tt = 4'b0111;
    rst_v = 3'b000; start_v = 3'b000; clr_v = 3'b000;
    mode0 = 3'd0; mode1 = 3'd3; mode2 = 3'd4;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      getObs(s, oa, ob, obusy, odone, opass, ovec, ocnt);
      chk("reset_outputs", 32'({oa, ob, obusy, odone, opass, ovec, ocnt}), 32'd0);
    end
    rst_v = 3'b111;

    applyStimulus(0, 1'b0, "nand", 4'b0000, 1'b1, 8'd0, 9);
    checkOutput(0);

    // A second start mid-run must not restart or shift the done pulse.
    applyStimulus(0, 1'b0, "restart", 4'b0000, 1'b1, 8'd0, 9);
    repeat (3) step();
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    checkOutput(0);

    mode0 = 3'd1;
    applyStimulus(0, 1'b0, "stuck1", 4'b1000, 1'b0, 8'd1, 9);
    checkOutput(0);

    // A 2-state simulator collapses X to a fixed value, so the expectation uses the same value.
    xvec = 4'd0;
    xcnt = 8'd0;
    for (int k = 0; k < 4; k++) begin
      xvec[k] = (xv !== nand_tt[k]);
      xcnt    = xcnt + 8'(xvec[k]);
    end
    mode0 = 3'd2;
    applyStimulus(0, 1'b1, "xrun_clr", xvec, 1'b0, xcnt, 9);
    checkOutput(0);

    mode0 = 3'd0;
    startRun(0, 1'b0);
    repeat (4) step();
    getObs(0, oa, ob, obusy, odone, opass, ovec, ocnt);
    chk("prereset_busy", 32'(obusy), 32'd1);
    rst_v[0] = 1'b0;
    #1;
    getObs(0, oa, ob, obusy, odone, opass, ovec, ocnt);
    chk("midrun_reset", 32'({oa, ob, obusy, odone, opass, ovec, ocnt}), 32'd0);
    repeat (2) step();
    rst_v[0] = 1'b1;
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done0 === 1'b1) done_count++;
    end
    chk("no_done_after_reset", 32'(done_count), 32'd0);
    applyStimulus(0, 1'b0, "after_reset", 4'b0000, 1'b1, 8'd0, 9);
    checkOutput(0);

    applyStimulus(1, 1'b0, "sat_run1", 4'b0111, 1'b0, 8'd3, 9);
    checkOutput(1);
    applyStimulus(1, 1'b0, "sat_run2", 4'b0111, 1'b0, 8'd3, 9);
    checkOutput(1);
    @(negedge clk);
    clr_v[1] = 1'b1;
    @(negedge clk);
    clr_v[1] = 1'b0;
    chk("sat_clr", 32'(cnt1), 32'd0);
    chk("clr_keeps_vec", 32'(vec1), 32'b0111);

    applyStimulus(2, 1'b0, "nor", 4'b0000, 1'b1, 8'd0, 5);
    checkOutput(2);
    mode2 = 3'd0;
    applyStimulus(2, 1'b0, "nor_vs_nand", 4'b0110, 1'b0, 8'd2, 5);
    checkOutput(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
